// File: rtl/skewed_sys_array.sv
// Weight-stationary systolic array with input skew and output deskew.
// Optional macro SYS_ARRAY_SAT_EN: saturating PE accumulation (default: wrap).
module skewed_sys_array #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int BITWIDTH = 8,
    parameter int ACCWIDTH = 20
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         w_valid,
    output logic                         w_ready,
    input  logic [COLS*BITWIDTH-1:0]     w_data,
    input  logic                         a_valid,
    output logic                         a_ready,
    input  logic [ROWS*BITWIDTH-1:0]     a_data,
    input  logic                         a_last,
    output logic                         c_valid,
    output logic [COLS*ACCWIDTH-1:0]     c_data,
    output logic                         c_last,
    output logic                         busy
);

    localparam int LAT = ROWS + COLS;
    localparam int SRL = LAT - 1;
    localparam int LCW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DCW = $clog2(LAT + 1);

    typedef logic signed [BITWIDTH-1:0] elem_t;
    typedef logic signed [ACCWIDTH-1:0] acc_t;
    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

`ifdef SYS_ARRAY_SAT_EN
    localparam acc_t ACC_MAX = {1'b0, {(ACCWIDTH-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACCWIDTH-1){1'b0}}};
`endif

    state_t         state;
    state_t         nxt;
    logic [LCW-1:0] load_cnt;
    logic [DCW-1:0] drain_cnt;
    logic           w_fire;
    logic           a_fire;
    logic           last_row;
    logic           drain_end;

    elem_t w_shadow [ROWS][COLS];
    elem_t w_active [ROWS][COLS];
    elem_t a_gate   [ROWS];
    elem_t skew_q   [ROWS][ROWS];
    elem_t row_in   [ROWS];
    elem_t a_in     [ROWS][COLS];
    elem_t a_q      [ROWS][COLS];
    acc_t  ps_in    [ROWS][COLS];
    acc_t  ps_d     [ROWS][COLS];
    acc_t  ps_q     [ROWS][COLS];
    acc_t  deskew_q [COLS][COLS];
    acc_t  col_out  [COLS];

    logic [SRL-1:0] vld_sr;
    logic [SRL-1:0] last_sr;

    // One PE step: full-width signed product added to the incoming partial sum.
    function automatic acc_t pe_mac(acc_t ps, elem_t a, elem_t w);
        logic signed [2*BITWIDTH-1:0] prod;
        acc_t                         ext;
`ifdef SYS_ARRAY_SAT_EN
        logic signed [ACCWIDTH:0]     wide;
`endif
        prod = (2*BITWIDTH)'(a) * (2*BITWIDTH)'(w);
        ext  = ACCWIDTH'(prod);
`ifdef SYS_ARRAY_SAT_EN
        wide = (ACCWIDTH+1)'(ps) + (ACCWIDTH+1)'(ext);
        if (wide[ACCWIDTH] != wide[ACCWIDTH-1])
            return wide[ACCWIDTH] ? ACC_MIN : ACC_MAX;
        return ACCWIDTH'(wide);
`else
        return ps + ext;
`endif
    endfunction

    assign w_fire    = w_valid & w_ready;
    assign a_fire    = a_valid & a_ready;
    assign last_row  = (int'(load_cnt) == ROWS - 1);
    assign drain_end = (int'(drain_cnt) == LAT - 1);

    // Next-state decode for the load/compute/drain sequence.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE, LOAD: begin
                if (w_fire)
                    nxt = last_row ? COMPUTE : LOAD;
            end
            COMPUTE: begin
                if (a_fire && a_last)
                    nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_end)
                    nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // FSM state, counters and registered handshake/status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            load_cnt  <= '0;
            drain_cnt <= '0;
            w_ready   <= 1'b1;
            a_ready   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state <= nxt;
            if (w_fire)
                load_cnt <= last_row ? '0 : load_cnt + LCW'(1);
            if (state == DRAIN)
                drain_cnt <= drain_end ? '0 : drain_cnt + DCW'(1);
            w_ready <= (nxt == IDLE) || (nxt == LOAD);
            a_ready <= (nxt == COMPUTE);
            busy    <= (nxt != IDLE);
        end
    end

    // Weight rows land in the shadow bank; the active bank is
    // refreshed with the complete set as the last row arrives.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int j = 0; j < COLS; j++) begin
                    w_shadow[r][j] <= '0;
                    w_active[r][j] <= '0;
                end
            end
        end else if (w_fire) begin
            for (int j = 0; j < COLS; j++)
                w_shadow[load_cnt][j] <= elem_t'(w_data[j*BITWIDTH +: BITWIDTH]);
            if (last_row) begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int j = 0; j < COLS; j++) begin
                        if (r == int'(load_cnt))
                            w_active[r][j] <= elem_t'(w_data[j*BITWIDTH +: BITWIDTH]);
                        else
                            w_active[r][j] <= w_shadow[r][j];
                    end
                end
            end
        end
    end

    // Gate activations by the handshake and pick each row's skewed tap.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            if (a_fire)
                a_gate[i] = elem_t'(a_data[i*BITWIDTH +: BITWIDTH]);
            else
                a_gate[i] = '0;
        end
        for (int i = 0; i < ROWS; i++) begin
            int unsigned k;
            k = (i > 0) ? i - 1 : 0;
            row_in[i] = (i == 0) ? a_gate[0] : skew_q[i][k];
        end
    end

    // PE grid: a flows right, partial sums flow down.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                int unsigned jm;
                int unsigned im;
                jm = (j > 0) ? j - 1 : 0;
                im = (i > 0) ? i - 1 : 0;
                a_in[i][j]  = (j == 0) ? row_in[i] : a_q[i][jm];
                ps_in[i][j] = (i == 0) ? '0 : ps_q[im][j];
                ps_d[i][j]  = pe_mac(ps_in[i][j], a_in[i][j], w_active[i][j]);
            end
        end
    end

    // Select each column's deskewed bottom partial sum.
    always_comb begin
        for (int j = 0; j < COLS; j++) begin
            int unsigned d;
            int unsigned dk;
            d  = COLS - 1 - j;
            dk = (d > 0) ? d - 1 : 0;
            col_out[j] = (d == 0) ? ps_q[ROWS-1][j] : deskew_q[j][dk];
        end
    end

    // Skew, PE, deskew and valid/last pipelines plus the output register.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ROWS; i++) begin
                for (int k = 0; k < ROWS; k++)
                    skew_q[i][k] <= '0;
                for (int j = 0; j < COLS; j++) begin
                    a_q[i][j]  <= '0;
                    ps_q[i][j] <= '0;
                end
            end
            for (int j = 0; j < COLS; j++) begin
                for (int k = 0; k < COLS; k++)
                    deskew_q[j][k] <= '0;
            end
            vld_sr  <= '0;
            last_sr <= '0;
            c_valid <= 1'b0;
            c_last  <= 1'b0;
            c_data  <= '0;
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                skew_q[i][0] <= a_gate[i];
                for (int k = 1; k < ROWS; k++)
                    skew_q[i][k] <= skew_q[i][k-1];
                for (int j = 0; j < COLS; j++) begin
                    a_q[i][j]  <= a_in[i][j];
                    ps_q[i][j] <= ps_d[i][j];
                end
            end
            for (int j = 0; j < COLS; j++) begin
                deskew_q[j][0] <= ps_q[ROWS-1][j];
                for (int k = 1; k < COLS; k++)
                    deskew_q[j][k] <= deskew_q[j][k-1];
            end
            vld_sr[0]  <= a_fire;
            last_sr[0] <= a_fire & a_last;
            for (int k = 1; k < SRL; k++) begin
                vld_sr[k]  <= vld_sr[k-1];
                last_sr[k] <= last_sr[k-1];
            end
            c_valid <= vld_sr[SRL-1];
            c_last  <= vld_sr[SRL-1] & last_sr[SRL-1];
            if (vld_sr[SRL-1]) begin
                for (int j = 0; j < COLS; j++)
                    c_data[j*ACCWIDTH +: ACCWIDTH] <= col_out[j];
            end
        end
    end

endmodule
